// File: rtl/rob_nway.sv
// rob_nway: N-way reorder buffer for the commit path of an out-of-order core.
//
// Dispatch writes up to DISPATCH_W entries at the tail per cycle.
// WB_W write-back ports mark entries executed and record the branch outcome.
// Up to COMMIT_W entries retire in order from the head. Retirement stops at
// the first entry that is not executed, or at the first entry that carries a
// mispredict, halt or illegal flag; that flagged entry still commits.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   dis_*             dispatch lanes (packed from lane 0), dis_ready, dis_robn
//   wb_*              write-back ports: valid, robn, mispredict, target
//   ct_*              commit lanes (packed): valid, dest arn/prn, pc, store count
//   squash, squash_pc a mispredicted entry commits; flush all and redirect
//   halted            sticky; a halt or illegal entry has committed
//   count             number of occupied entries
module rob_nway #(
    parameter int DEPTH      = 32,
    parameter int DISPATCH_W = 3,
    parameter int WB_W       = 4,
    parameter int COMMIT_W   = 3,
    parameter int PRN_W      = 6,
    localparam int AW        = $clog2(DEPTH),
    localparam int CNTW      = AW + 1,
    localparam int SNW       = $clog2(COMMIT_W) + 1,
    localparam int DCW       = $clog2(DISPATCH_W) + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DISPATCH_W-1:0]       dis_valid,
    input  logic [DISPATCH_W*5-1:0]     dis_dest_arn,
    input  logic [DISPATCH_W*PRN_W-1:0] dis_dest_prn,
    input  logic [DISPATCH_W*32-1:0]    dis_pc,
    input  logic [DISPATCH_W-1:0]       dis_is_store,
    input  logic [DISPATCH_W-1:0]       dis_halt,
    input  logic [DISPATCH_W-1:0]       dis_illegal,
    output logic                        dis_ready,
    output logic [DISPATCH_W*AW-1:0]    dis_robn,
    input  logic [WB_W-1:0]             wb_valid,
    input  logic [WB_W*AW-1:0]          wb_robn,
    input  logic [WB_W-1:0]             wb_mispredict,
    input  logic [WB_W*32-1:0]          wb_target,
    output logic [COMMIT_W-1:0]         ct_valid,
    output logic [COMMIT_W*5-1:0]       ct_dest_arn,
    output logic [COMMIT_W*PRN_W-1:0]   ct_dest_prn,
    output logic [COMMIT_W*32-1:0]      ct_pc,
    output logic [SNW-1:0]              ct_store_num,
    output logic                        squash,
    output logic [31:0]                 squash_pc,
    output logic                        halted,
    output logic [CNTW-1:0]             count
);

    // Control state (reset)
    logic [DEPTH-1:0] ent_vld;
    logic [DEPTH-1:0] ent_exec;
    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;

    // Payload (not reset; only observed through valid, executed entries)
    logic [DEPTH-1:0] ent_mis;
    logic [DEPTH-1:0] ent_store;
    logic [DEPTH-1:0] ent_halt;
    logic [DEPTH-1:0] ent_illegal;
    logic [31:0]      ent_target [DEPTH];
    logic [31:0]      ent_pc     [DEPTH];
    logic [4:0]       ent_arn    [DEPTH];
    logic [PRN_W-1:0] ent_prn    [DEPTH];

    logic [SNW-1:0]   n_commit;
    logic             halt_commit;
    logic             stop;
    logic [AW-1:0]    cidx;
    logic             dis_acc;
    logic [DCW-1:0]   n_dis;

    // Readiness uses the registered count only; same-cycle commits are not credited.
    assign dis_ready = (int'(count) + DISPATCH_W <= DEPTH) && !halted;
    assign dis_acc   = dis_ready && !squash;

    always_comb begin
        n_dis = '0;
        for (int i = 0; i < DISPATCH_W; i++) begin
            dis_robn[i*AW +: AW] = tail + AW'(i);
            if (dis_acc && dis_valid[i]) n_dis = n_dis + DCW'(1);
        end
    end

    // In-order commit window: a lane is valid only while every lane below it
    // committed and none of them ended the window with a flag.
    always_comb begin
        ct_valid     = '0;
        ct_dest_arn  = '0;
        ct_dest_prn  = '0;
        ct_pc        = '0;
        ct_store_num = '0;
        squash       = 1'b0;
        squash_pc    = '0;
        n_commit     = '0;
        halt_commit  = 1'b0;
        stop         = halted;
        cidx         = head;
        for (int k = 0; k < COMMIT_W; k++) begin
            cidx = head + AW'(k);
            if (!stop && ent_vld[cidx] && ent_exec[cidx]) begin
                ct_valid[k]                 = 1'b1;
                ct_dest_arn[k*5 +: 5]       = ent_arn[cidx];
                ct_dest_prn[k*PRN_W +: PRN_W] = ent_prn[cidx];
                ct_pc[k*32 +: 32]           = ent_pc[cidx];
                n_commit                    = n_commit + SNW'(1);
                if (ent_store[cidx]) ct_store_num = ct_store_num + SNW'(1);
                if (ent_mis[cidx]) begin
                    squash    = 1'b1;
                    squash_pc = ent_target[cidx];
                end
                if (ent_halt[cidx] || ent_illegal[cidx]) halt_commit = 1'b1;
                if (ent_mis[cidx] || ent_halt[cidx] || ent_illegal[cidx]) stop = 1'b1;
            end else begin
                stop = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_vld  <= '0;
            ent_exec <= '0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            halted   <= 1'b0;
        end else begin
            halted <= halted | halt_commit;
            if (squash) begin
                // Full flush; this cycle's dispatch is discarded via dis_acc.
                ent_vld  <= '0;
                ent_exec <= '0;
                head     <= '0;
                tail     <= '0;
                count    <= '0;
            end else begin
                for (int w = 0; w < WB_W; w++) begin
                    if (wb_valid[w] && ent_vld[wb_robn[w*AW +: AW]])
                        ent_exec[wb_robn[w*AW +: AW]] <= 1'b1;
                end
                for (int k = 0; k < COMMIT_W; k++) begin
                    if (ct_valid[k]) ent_vld[head + AW'(k)] <= 1'b0;
                end
                for (int i = 0; i < DISPATCH_W; i++) begin
                    if (dis_acc && dis_valid[i]) begin
                        ent_vld[tail + AW'(i)]  <= 1'b1;
                        ent_exec[tail + AW'(i)] <= 1'b0;
                    end
                end
                head  <= head + AW'(n_commit);
                tail  <= tail + AW'(n_dis);
                count <= count + CNTW'(n_dis) - CNTW'(n_commit);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int w = 0; w < WB_W; w++) begin
            if (wb_valid[w] && ent_vld[wb_robn[w*AW +: AW]]) begin
                ent_mis[wb_robn[w*AW +: AW]]    <= wb_mispredict[w];
                ent_target[wb_robn[w*AW +: AW]] <= wb_target[w*32 +: 32];
            end
        end
        for (int i = 0; i < DISPATCH_W; i++) begin
            if (dis_acc && dis_valid[i]) begin
                ent_mis[tail + AW'(i)]     <= 1'b0;
                ent_store[tail + AW'(i)]   <= dis_is_store[i];
                ent_halt[tail + AW'(i)]    <= dis_halt[i];
                ent_illegal[tail + AW'(i)] <= dis_illegal[i];
                ent_pc[tail + AW'(i)]      <= dis_pc[i*32 +: 32];
                ent_arn[tail + AW'(i)]     <= dis_dest_arn[i*5 +: 5];
                ent_prn[tail + AW'(i)]     <= dis_dest_prn[i*PRN_W +: PRN_W];
            end
        end
    end

endmodule
